// File: rtl/tc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tc_pkg
// Description : Shared light codes, lane state encoding and light-code
//               legality helper for the traffic-light street model.
// Revision    : 1.0 - initial release
// ============================================================================
package tc_pkg;

    // One-hot light codes driven by the controller
    localparam logic [2:0] TC_GREEN  = 3'b100;
    localparam logic [2:0] TC_YELLOW = 3'b010;
    localparam logic [2:0] TC_RED    = 3'b001;

    // Per-street lane state: STOP holds cars, GO lets them depart
    typedef enum logic [0:0] {
        LANE_STOP = 1'b0,
        LANE_GO   = 1'b1
    } lane_state_t;

    // A light code is legal only when it is exactly one of the three colours
    function automatic logic tc_light_legal(input logic [2:0] code);
        return (code == TC_GREEN) || (code == TC_YELLOW) || (code == TC_RED);
    endfunction

endpackage : tc_pkg
`default_nettype wire

// File: rtl/tc_lane_queue.sv
`default_nettype none
// ============================================================================
// Module      : tc_lane_queue
// Description : One street lane: saturating car queue, lane STOP/GO FSM with
//               a departure timer, and a one-cycle drop pulse when an arrival
//               hits a full queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tc_lane_queue
    import tc_pkg::*;
#(
    parameter int QW         = 4,
    parameter int DEPART_CYC = 2
) (
    input  logic          CLK,
    input  logic          R,
    input  logic          i_arrival,
    input  logic          i_green,
    input  logic          i_freeze,
    output logic [QW-1:0] o_q,
    output logic          o_t,
    output logic          o_drop
);

    localparam logic [QW-1:0] c_q_max      = '1;
    localparam logic [QW-1:0] c_q_one      = QW'(1);
    localparam logic [7:0]    c_timer_last = 8'(DEPART_CYC - 1);

    lane_state_t   r_state;
    lane_state_t   w_state_nxt;
    logic [7:0]    r_timer;
    logic [7:0]    w_timer_nxt;
    logic [QW-1:0] r_q;
    logic [QW-1:0] w_q_nxt;
    logic          r_drop;
    logic          w_drop_nxt;
    logic          w_eligible;
    logic          w_depart;

    // Cars may move only on green, with something queued, and no fault
    assign w_eligible = i_green && (r_q != '0) && !i_freeze;

    // Lane FSM and departure timer: a car leaves after DEPART_CYC GO cycles
    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_depart    = 1'b0;
        case (r_state)
            LANE_STOP: begin
                w_timer_nxt = 8'd0;
                if (w_eligible) begin
                    w_state_nxt = LANE_GO;
                end
            end
            LANE_GO: begin
                if (!w_eligible) begin
                    // Leaving green, empty queue or fault: discard progress
                    w_state_nxt = LANE_STOP;
                    w_timer_nxt = 8'd0;
                end else if (r_timer == c_timer_last) begin
                    w_depart    = 1'b1;
                    w_timer_nxt = 8'd0;
                end else begin
                    w_timer_nxt = r_timer + 8'd1;
                end
            end
            default: begin
                w_state_nxt = LANE_STOP;
                w_timer_nxt = 8'd0;
            end
        endcase
    end

    // Saturating queue: simultaneous arrival and departure cancel out
    always_comb begin
        w_q_nxt    = r_q;
        w_drop_nxt = 1'b0;
        if (i_arrival && !w_depart) begin
            if (r_q != c_q_max) begin
                w_q_nxt = r_q + c_q_one;
            end else begin
                w_drop_nxt = 1'b1;
            end
        end else if (w_depart && !i_arrival) begin
            w_q_nxt = r_q - c_q_one;
        end
    end

    // State, timer, queue and drop registers
    always_ff @(posedge CLK or negedge R) begin
        if (!R) begin
            r_state <= LANE_STOP;
            r_timer <= 8'd0;
            r_q     <= '0;
            r_drop  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
            r_q     <= w_q_nxt;
            r_drop  <= w_drop_nxt;
        end
    end

    assign o_q    = r_q;
    assign o_t    = (r_q != '0);
    assign o_drop = r_drop;

endmodule : tc_lane_queue
`default_nettype wire

// File: rtl/tc_traffic_model.sv
`default_nettype none
// ============================================================================
// Module      : tc_traffic_model
// Description : Closed-loop two-street traffic model for the traffic-light
//               controller. Queues cars per street, releases them on green,
//               reports drops and latches a sticky illegal-light fault.
//               Optional macro TC_MODEL_ARR_LFSR_EN adds LFSR-generated
//               pseudo-random arrivals on top of ARR_A/ARR_B.
// Revision    : 1.0 - initial release
// ============================================================================
module tc_traffic_model
    import tc_pkg::*;
#(
    parameter int         QW         = 4,
    parameter int         DEPART_CYC = 2,
    parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
    input  logic          CLK,
    input  logic          R,
    input  logic          ARR_A,
    input  logic          ARR_B,
    input  logic [2:0]    L_A,
    input  logic [2:0]    L_B,
    output logic          T_A,
    output logic          T_B,
    output logic [QW-1:0] Q_A,
    output logic [QW-1:0] Q_B,
    output logic          DROP_A,
    output logic          DROP_B,
    output logic          FAULT
);

    logic w_arr_a;
    logic w_arr_b;
    logic w_fault_now;
    logic r_fault;

`ifdef TC_MODEL_ARR_LFSR_EN
    logic [7:0] r_lfsr;
    logic       w_lfsr_fb;

    // Fibonacci taps for x^8+x^6+x^5+x^4+1
    assign w_lfsr_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

    // Free-running arrival generator
    always_ff @(posedge CLK or negedge R) begin
        if (!R) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= {r_lfsr[6:0], w_lfsr_fb};
        end
    end

    assign w_arr_a = ARR_A | (r_lfsr[2:0] == 3'b111);
    assign w_arr_b = ARR_B | (r_lfsr[5:3] == 3'b111);
`else
    logic w_unused_seed;

    assign w_unused_seed = ^LFSR_SEED;
    assign w_arr_a       = ARR_A;
    assign w_arr_b       = ARR_B;
`endif

    // Illegal code on either street, or neither street showing red
    assign w_fault_now = !tc_light_legal(L_A) || !tc_light_legal(L_B) ||
                         ((L_A != TC_RED) && (L_B != TC_RED));

    // Sticky fault flag, cleared only by reset
    always_ff @(posedge CLK or negedge R) begin
        if (!R) begin
            r_fault <= 1'b0;
        end else begin
            r_fault <= r_fault | w_fault_now;
        end
    end

    assign FAULT = r_fault;

    tc_lane_queue #(
        .QW         (QW),
        .DEPART_CYC (DEPART_CYC)
    ) u_lane_a (
        .CLK        (CLK),
        .R          (R),
        .i_arrival  (w_arr_a),
        .i_green    (L_A == TC_GREEN),
        .i_freeze   (r_fault),
        .o_q        (Q_A),
        .o_t        (T_A),
        .o_drop     (DROP_A)
    );

    tc_lane_queue #(
        .QW         (QW),
        .DEPART_CYC (DEPART_CYC)
    ) u_lane_b (
        .CLK        (CLK),
        .R          (R),
        .i_arrival  (w_arr_b),
        .i_green    (L_B == TC_GREEN),
        .i_freeze   (r_fault),
        .o_q        (Q_B),
        .o_t        (T_B),
        .o_drop     (DROP_B)
    );

endmodule : tc_traffic_model
`default_nettype wire

// File: tb/tb_tc_traffic_model.sv
`default_nettype none
// ============================================================================
// Module      : tb_tc_traffic_model
// Description : Randomized scoreboard bench for tc_traffic_model. A
//               behavioural street model predicts each cycle's outputs; a
//               monitor compares them against the DUT on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tc_traffic_model;

    localparam int         QW    = 4;
    localparam int         DEP   = 2;
    localparam int         QMAX  = (1 << QW) - 1;
    localparam logic [7:0] SEED  = 8'hA5;
    localparam logic [2:0] GRN   = 3'b100;
    localparam logic [2:0] YEL   = 3'b010;
    localparam logic [2:0] RED   = 3'b001;

    logic          CLK;
    logic          R;
    logic          ARR_A, ARR_B;
    logic [2:0]    L_A, L_B;
    logic          T_A, T_B;
    logic [QW-1:0] Q_A, Q_B;
    logic          DROP_A, DROP_B;
    logic          FAULT;

    tc_traffic_model #(
        .QW         (QW),
        .DEPART_CYC (DEP),
        .LFSR_SEED  (SEED)
    ) dut (
        .CLK    (CLK),
        .R      (R),
        .ARR_A  (ARR_A),
        .ARR_B  (ARR_B),
        .L_A    (L_A),
        .L_B    (L_B),
        .T_A    (T_A),
        .T_B    (T_B),
        .Q_A    (Q_A),
        .Q_B    (Q_B),
        .DROP_A (DROP_A),
        .DROP_B (DROP_B),
        .FAULT  (FAULT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [3:0] qa;
        logic [3:0] qb;
        logic       ta;
        logic       tb;
        logic       da;
        logic       db;
        logic       f;
    } obs_t;

    obs_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Street model: cars waiting, whether the street is moving, how many
    // moving cycles have elapsed toward the next car leaving
    int         m_q[2];
    bit         m_moving[2];
    int         m_run[2];
    bit         m_drop[2];
    bit         m_fault;
    logic [7:0] m_lfsr;

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_q[i] = 0; m_moving[i] = 0; m_run[i] = 0; m_drop[i] = 0;
        end
        m_fault = 0;
        m_lfsr  = SEED;
    endfunction

    function automatic bit legal(logic [2:0] c);
        return (c == GRN) || (c == YEL) || (c == RED);
    endfunction

    function automatic void model_step(bit aa, bit ab, logic [2:0] la, logic [2:0] lb);
        bit arr[2];
        bit grn[2];
        bit may_go;
        bit leaves;
        arr[0] = aa;
        arr[1] = ab;
`ifdef TC_MODEL_ARR_LFSR_EN
        arr[0] = arr[0] | (m_lfsr[2:0] == 3'b111);
        arr[1] = arr[1] | (m_lfsr[5:3] == 3'b111);
        m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
`endif
        grn[0] = (la == GRN);
        grn[1] = (lb == GRN);
        for (int i = 0; i < 2; i++) begin
            may_go = grn[i] && (m_q[i] > 0) && !m_fault;
            leaves = 0;
            if (!may_go) begin
                m_moving[i] = 0;
                m_run[i]    = 0;
            end else if (!m_moving[i]) begin
                m_moving[i] = 1;
                m_run[i]    = 0;
            end else begin
                m_run[i] = m_run[i] + 1;
                if (m_run[i] == DEP) begin
                    leaves   = 1;
                    m_run[i] = 0;
                end
            end
            m_drop[i] = 0;
            if (arr[i] && !leaves) begin
                if (m_q[i] < QMAX) m_q[i] = m_q[i] + 1;
                else               m_drop[i] = 1;
            end else if (leaves && !arr[i]) begin
                m_q[i] = m_q[i] - 1;
            end
        end
        if (!legal(la) || !legal(lb) || (la != RED && lb != RED)) m_fault = 1;
    endfunction

    function automatic obs_t model_obs();
        obs_t o;
        o.qa = 4'(m_q[0]);
        o.qb = 4'(m_q[1]);
        o.ta = (m_q[0] != 0);
        o.tb = (m_q[1] != 0);
        o.da = m_drop[0];
        o.db = m_drop[1];
        o.f  = m_fault;
        return o;
    endfunction

    task automatic compare(string name, obs_t act, obs_t e);
        n_tests++;
        if (act !== e) begin
            n_fail++;
            $display("FAIL %s t=%0t actual qa=%0d qb=%0d ta=%0b tb=%0b da=%0b db=%0b f=%0b required qa=%0d qb=%0d ta=%0b tb=%0b da=%0b db=%0b f=%0b",
                     name, $time, act.qa, act.qb, act.ta, act.tb, act.da, act.db, act.f,
                     e.qa, e.qb, e.ta, e.tb, e.da, e.db, e.f);
        end
    endtask

    // Monitor: every falling edge the DUT presents one cycle's outputs
    always @(negedge CLK) begin
        obs_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            compare("cycle_out", {Q_A, Q_B, T_A, T_B, DROP_A, DROP_B, FAULT}, e);
        end
    end

    function automatic logic [2:0] pick_legal();
        case ($urandom_range(0, 4))
            0:       return GRN;
            1:       return YEL;
            default: return RED;
        endcase
    endfunction

    // Light modes: 0 A green, 1 B green, 2 both red, 3 random legal,
    // 4 random with rare illegal codes, 5 A green/yellow toggle, 6 A=011
    task automatic run_phase(int cycles, int mode, int pa, int pb);
        for (int c = 0; c < cycles; c++) begin
            ARR_A = ($urandom_range(0, 99) < pa);
            ARR_B = ($urandom_range(0, 99) < pb);
            case (mode)
                0: begin L_A = GRN; L_B = RED; end
                1: begin L_A = RED; L_B = GRN; end
                2: begin L_A = RED; L_B = RED; end
                3, 4: begin
                    if ($urandom_range(0, 3) == 0) begin
                        if ($urandom_range(0, 1) == 0) begin
                            L_A = pick_legal(); L_B = RED;
                        end else begin
                            L_A = RED; L_B = pick_legal();
                        end
                    end
                    if (mode == 4 && $urandom_range(0, 19) == 0) begin
                        L_A = 3'($urandom_range(0, 7));
                        L_B = 3'($urandom_range(0, 7));
                    end
                end
                5: begin L_A = (c % 2 == 0) ? GRN : YEL; L_B = RED; end
                default: begin L_A = 3'b011; L_B = RED; end
            endcase
            @(posedge CLK);
            model_step(ARR_A, ARR_B, L_A, L_B);
            exp_q.push_back(model_obs());
            @(negedge CLK);
        end
    endtask

    // Asynchronous reset check, held across one rising edge
    task automatic do_reset();
        #2;
        R = 1'b0;
        #1;
        compare("async_reset", {Q_A, Q_B, T_A, T_B, DROP_A, DROP_B, FAULT}, '0);
        model_reset();
        @(posedge CLK);
        exp_q.push_back(model_obs());
        @(negedge CLK);
        R = 1'b1;
    endtask

    initial begin
        R = 1'b0; ARR_A = 0; ARR_B = 0; L_A = GRN; L_B = RED;
        model_reset();
        #1;
        compare("reset_state", {Q_A, Q_B, T_A, T_B, DROP_A, DROP_B, FAULT}, '0);
        @(negedge CLK);
        R = 1'b1;

        run_phase(3,   0, 0,   100);  // B builds to 3 while A idles
        run_phase(20,  2, 100, 0);    // A fills to max, then drops
        run_phase(10,  0, 100, 0);    // arrival meets departure at max
        run_phase(40,  0, 0,   0);    // A drains to 0
        run_phase(400, 3, 40,  40);   // random legal traffic
        run_phase(7,   0, 30,  0);
        do_reset();                   // reset with a departure in progress
        run_phase(10,  2, 50,  0);
        run_phase(20,  5, 0,   0);    // 1-cycle greens never release a car
        run_phase(30,  1, 0,   30);
        run_phase(3,   6, 0,   0);    // illegal code sets fault
        run_phase(30,  0, 40,  40);   // departures frozen, arrivals kept
        do_reset();
        run_phase(300, 4, 50,  50);   // random with rare illegal lights
        do_reset();
        run_phase(256, 2, 0,   0);    // only generated arrivals, if any

        @(negedge CLK);
        #1;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain actual %0d pending required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_tc_traffic_model
`default_nettype wire

// File: doc/tc_traffic_model.md
Name: tc_traffic_model

Overview:
Closed-loop street model for the two-street traffic-light controller. It consumes the controller's light codes L_A/L_B and produces the controller's sensor inputs T_A/T_B. It keeps a per-street vehicle queue: arrivals are queued, and cars depart only on green. It also flags illegal light states, so controller benches and FPGA demos run against realistic traffic.

Parameters:
QW, 4, queue counter width; capacity 2**QW-1 cars (15)
DEPART_CYC, 2, cycles of continuous green per departing car; legal range 1..255
LFSR_SEED, 8'hA5, LFSR reset value when ARR_LFSR_EN is defined; must be nonzero

Ports:
CLK  in  1  clock, rising edge
R  in  1  reset, asynchronous, active-low
ARR_A  in  1  car arrival on street A, one car per cycle high
ARR_B  in  1  car arrival on street B
L_A  in  3  street A light: 100 green, 010 yellow, 001 red
L_B  in  3  street B light, same encoding
T_A  out  1  traffic present on A = (Q_A != 0)
T_B  out  1  traffic present on B = (Q_B != 0)
Q_A  out  QW  cars queued on A
Q_B  out  QW  cars queued on B
DROP_A  out  1  one-cycle pulse: A arrival lost, queue full
DROP_B  out  1  one-cycle pulse: B arrival lost
FAULT  out  1  sticky illegal-light flag

Behaviour:
- Reset (R=0, async): Q_A=Q_B=0, so T_A=T_B=0. DROP_A=DROP_B=0, FAULT=0, both lane FSMs in STOP, timers 0, LFSR=LFSR_SEED.
- T_X is combinational from registered Q_X; no extra latency.
- Lane FSM, per street:
  - STOP: light is not green, or Q=0. Timer held at 0.
  - GO: light is green, Q>0 and FAULT=0.
  - STOP->GO on the edge where that condition first holds. Timer counts up each GO cycle.
  - When timer==DEPART_CYC-1: one departure this edge, timer returns to 0.
  - GO->STOP when the light leaves green, Q reaches 0, or FAULT sets. Timer clears; partial progress is discarded.
- Yellow counts as not green: no departures.
- Queue update per edge:
  - Arrival only: Q+1 if Q<max; otherwise Q stays at max and DROP pulses for 1 cycle.
  - Departure only: Q-1.
  - Arrival and departure together: Q unchanged, no DROP, even at max.
  - Q never wraps in either direction.
- Fault check on every edge:
  - Either light code is not one of {100,010,001}, or both lights are not red at once.
  - FAULT sets on that edge and holds until reset.
  - While FAULT=1: departures frozen, arrivals still accepted, drops still reported.
- Reset mid-operation: everything returns to reset values immediately, including an in-progress departure timer and FAULT.
- DEPART_CYC=1: one departure every green cycle while Q>0.

Optional Feature:
TC_MODEL_ARR_LFSR_EN
- Defined:
  - An 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1, advances every cycle from LFSR_SEED.
  - Effective arrival A = ARR_A | (lfsr[2:0]==3'b111).
  - Effective arrival B = ARR_B | (lfsr[5:3]==3'b111).
  - Effective arrivals feed the queue and DROP logic exactly like external ones.
- Undefined: no LFSR logic; arrivals come from ARR_A/ARR_B only; LFSR_SEED is unused.

Decomposition:
- Package tc_pkg:
  - Light codes TC_GREEN=3'b100, TC_YELLOW=3'b010, TC_RED=3'b001.
  - Lane state encoding LANE_STOP/LANE_GO.
  - Function tc_light_legal(code).
- Sub-module tc_lane_queue, instantiated once per street.
  - Contains the lane FSM, departure timer, saturating queue and DROP.
  - Inputs: arrival, green, freeze.
  - Outputs: Q, T, DROP.
- Top level holds the fault checker and the optional LFSR.

Test Plan:
- Reset with L_A=100, L_B=001: drive ARR_B for 3 cycles -> Q_B=3, T_B=1, Q_A=0, T_A=0, FAULT=0.
- Q_A=4, L_A=100, L_B=001, DEPART_CYC=2 -> Q_A decrements every 2nd edge: 4,3,2,1,0; T_A falls in the cycle Q_A hits 0.
- Q_A=15 with L_A=001: ARR_A high 2 cycles -> Q_A stays 15, DROP_A pulses 2 cycles. Then ARR_A high while green at a departure edge -> Q_A=15, no DROP_A.
- L_A=100, L_B=010 for one cycle -> FAULT=1 next edge and held. A subsequent green with Q_A=5 -> Q_A remains 5. Assert R=0 -> FAULT=0 asynchronously.
- L_A=011 (illegal) -> FAULT=1. Separately, green for 1 cycle with DEPART_CYC=2, then yellow, then green 1 cycle -> no departure (timer cleared).
- With TC_MODEL_ARR_LFSR_EN, seed 8'hA5, ARR inputs 0, both red for 256 cycles -> Q_A/Q_B nonzero and match the reference LFSR model count; without the macro -> both stay 0.
